// File: rtl/iq_rx_scheduler_if.sv
// Bus bundle between the RX IQ scheduler, the DDC sample sources and the MCU interface FSM.
// slave = scheduler view, master = source/requester view.
interface iq_rx_scheduler_if #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 16
);
  logic                     rx1_en;
  logic                     rx2_en;
  logic signed [DATA_W-1:0] rx1_i;
  logic signed [DATA_W-1:0] rx1_q;
  logic                     rx1_valid;
  logic signed [DATA_W-1:0] rx2_i;
  logic signed [DATA_W-1:0] rx2_q;
  logic                     rx2_valid;
  logic                     read_req;
  logic signed [DATA_W-1:0] out_i;
  logic signed [DATA_W-1:0] out_q;
  logic                     out_ch;
  logic                     out_valid;
  logic                     out_empty;
  logic                     overrun;
  logic                     overrun_clr;
  logic [CNT_W-1:0]         overrun_cnt;

  modport slave (
    input  rx1_en, rx2_en, rx1_i, rx1_q, rx1_valid, rx2_i, rx2_q, rx2_valid,
    input  read_req, overrun_clr,
    output out_i, out_q, out_ch, out_valid, out_empty, overrun, overrun_cnt
  );

  modport master (
    output rx1_en, rx2_en, rx1_i, rx1_q, rx1_valid, rx2_i, rx2_q, rx2_valid,
    output read_req, overrun_clr,
    input  out_i, out_q, out_ch, out_valid, out_empty, overrun, overrun_cnt
  );
endinterface

// File: rtl/iq_rx_scheduler.sv
// Per-channel IQ FIFOs for RX1/RX2 with frame-ordered readout (RX1 then RX2) toward the MCU bus.
// Define IQ_SCHED_OVERRUN_CNT_EN to build the saturating dropped-pair counter on overrun_cnt.
module iq_rx_scheduler #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic clk_in,
  input  logic reset_in,
  iq_rx_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {S_RX1 = 1'b0, S_RX2 = 1'b1} state_t;
  state_t state, state_nxt;

  logic [1:0]          en, vld, empty, full, pop, push, drop;
  logic [2*DATA_W-1:0] wdata [2];
  logic [2*DATA_W-1:0] mem   [2][DEPTH];
  logic [PW-1:0]       wr_ptr [2];
  logic [PW-1:0]       rd_ptr [2];
  logic                sel;
  logic [2*DATA_W-1:0] rdata;

  assign en       = {bus.rx2_en, bus.rx1_en};
  assign vld      = {bus.rx2_valid, bus.rx1_valid};
  assign wdata[0] = {bus.rx1_i, bus.rx1_q};
  assign wdata[1] = {bus.rx2_i, bus.rx2_q};

  // A disabled RX2 slot falls back to RX1 in the same cycle it is requested.
  always_comb begin
    sel = (state == S_RX2) && bus.rx2_en;
    for (int c = 0; c < 2; c++) begin
      empty[c] = (wr_ptr[c] == rd_ptr[c]);
      full[c]  = (wr_ptr[c][PW-1] != rd_ptr[c][PW-1]) &&
                 (wr_ptr[c][AW-1:0] == rd_ptr[c][AW-1:0]);
      pop[c]   = bus.read_req && (int'(sel) == c) && !empty[c];
      push[c]  = vld[c] && en[c] && (!full[c] || pop[c]);
      drop[c]  = vld[c] && en[c] && full[c] && !pop[c];
    end
    rdata = mem[sel][rd_ptr[sel][AW-1:0]];
  end

  always_ff @(posedge clk_in) begin
    for (int c = 0; c < 2; c++) begin
      if (reset_in || !en[c]) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end else begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PW'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) mem[c][wr_ptr[c][AW-1:0]] <= wdata[c];
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) state <= S_RX1;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.read_req) begin
      state_nxt = (!sel && bus.rx2_en) ? S_RX2 : S_RX1;
    end else if (state == S_RX2 && !bus.rx2_en) begin
      state_nxt = S_RX1;
    end
  end

  // Output register stage: request in cycle t, pair presented in t+1.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      bus.out_valid <= 1'b0;
      bus.out_ch    <= 1'b0;
      bus.out_empty <= 1'b0;
      bus.out_i     <= '0;
      bus.out_q     <= '0;
    end else begin
      bus.out_valid <= bus.read_req;
      if (bus.read_req) begin
        bus.out_ch    <= sel;
        bus.out_empty <= empty[sel];
        bus.out_i     <= empty[sel] ? '0 : rdata[2*DATA_W-1:DATA_W];
        bus.out_q     <= empty[sel] ? '0 : rdata[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in)             bus.overrun <= 1'b0;
    else if (|drop)           bus.overrun <= 1'b1;
    else if (bus.overrun_clr) bus.overrun <= 1'b0;
  end

`ifdef IQ_SCHED_OVERRUN_CNT_EN
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [1:0]       n_drop;
  assign n_drop = {1'b0, drop[0]} + {1'b0, drop[1]};

  // A clear in the same cycle as a drop restarts the count from that drop.
  always_ff @(posedge clk_in) begin
    if (reset_in)             cnt <= '0;
    else if (bus.overrun_clr) cnt <= sat_add('0, n_drop);
    else                      cnt <= sat_add(cnt, n_drop);
  end
  assign bus.overrun_cnt = cnt;
`else
  assign bus.overrun_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_iq_rx_scheduler.sv
// Randomized and directed bench for iq_rx_scheduler against a queue-based frame-order model.
module tb_iq_rx_scheduler;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iq_rx_scheduler_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus();
  iq_rx_scheduler #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_in(clk), .reset_in(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: two queues plus the frame slot that the next request consumes.
  logic [47:0] q1[$];
  logic [47:0] q2[$];
  int          slot;
  logic        m_valid, m_ch, m_empty, m_ovr;
  logic [23:0] m_i, m_q;
  int          m_cnt;

  task automatic model_edge();
    logic [47:0] d;
    int ch, drops;
    if (rst) begin
      q1.delete(); q2.delete();
      slot = 0; m_valid = 0; m_ch = 0; m_empty = 0; m_i = 0; m_q = 0; m_ovr = 0; m_cnt = 0;
      return;
    end
    ch = (slot == 1 && bus.rx2_en) ? 1 : 0;
    m_valid = bus.read_req;
    if (bus.read_req) begin
      m_ch = ch[0];
      if (ch == 0 && q1.size() > 0)      begin d = q1.pop_front(); m_empty = 0; end
      else if (ch == 1 && q2.size() > 0) begin d = q2.pop_front(); m_empty = 0; end
      else                               begin d = '0; m_empty = 1; end
      m_i = d[47:24];
      m_q = d[23:0];
      slot = (ch == 0 && bus.rx2_en) ? 1 : 0;
    end else if (!bus.rx2_en) begin
      slot = 0;
    end
    drops = 0;
    if (!bus.rx1_en) q1.delete();
    else if (bus.rx1_valid) begin
      if (q1.size() < DEPTH) q1.push_back({bus.rx1_i, bus.rx1_q});
      else drops++;
    end
    if (!bus.rx2_en) q2.delete();
    else if (bus.rx2_valid) begin
      if (q2.size() < DEPTH) q2.push_back({bus.rx2_i, bus.rx2_q});
      else drops++;
    end
    if (drops > 0) m_ovr = 1;
    else if (bus.overrun_clr) m_ovr = 0;
    m_cnt = bus.overrun_clr ? drops : m_cnt + drops;
    if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
  endtask

  task automatic compare_all();
    int exp_cnt;
`ifdef IQ_SCHED_OVERRUN_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    check("out_ch",    64'(bus.out_ch),    64'(m_ch));
    check("out_empty", 64'(bus.out_empty), 64'(m_empty));
    check("out_i",     64'($unsigned(bus.out_i)), 64'(m_i));
    check("out_q",     64'($unsigned(bus.out_q)), 64'(m_q));
    check("overrun",   64'(bus.overrun),   64'(m_ovr));
    check("overrun_cnt", 64'(bus.overrun_cnt), 64'(exp_cnt));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
    bus.rx1_valid = 0; bus.rx2_valid = 0; bus.read_req = 0; bus.overrun_clr = 0;
  endtask

  task automatic push(input int ch, input logic [23:0] i, input logic [23:0] q);
    if (ch == 0) begin bus.rx1_valid = 1; bus.rx1_i = i; bus.rx1_q = q; end
    else         begin bus.rx2_valid = 1; bus.rx2_i = i; bus.rx2_q = q; end
  endtask

  initial begin
    rst = 1;
    bus.rx1_en = 0; bus.rx2_en = 0; bus.rx1_valid = 0; bus.rx2_valid = 0;
    bus.rx1_i = 0; bus.rx1_q = 0; bus.rx2_i = 0; bus.rx2_q = 0;
    bus.read_req = 0; bus.overrun_clr = 0;
    step(); step();
    check("reset_valid", 64'(bus.out_valid), 64'd0);
    rst = 0;

    // Single RX1 pair, one-cycle latency.
    bus.rx1_en = 1;
    push(0, 24'h000001, 24'h7FFFFF); step();
    bus.read_req = 1; step();
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_i", 64'($unsigned(bus.out_i)), 64'h000001);
    check("t1_q", 64'($unsigned(bus.out_q)), 64'h7FFFFF);
    check("t1_ch", 64'(bus.out_ch), 64'd0);

    // Interleaved RX1/RX2 frame order.
    bus.rx2_en = 1;
    push(0, 24'hA0000A, 24'hA1); step();
    push(1, 24'hB0000B, 24'hB1); step();
    push(0, 24'hC0000C, 24'hC1); step();
    push(1, 24'hD0000D, 24'hD1); step();
    for (int k = 0; k < 4; k++) begin
      bus.read_req = 1; step();
      check("t2_ch", 64'(bus.out_ch), 64'(k % 2));
    end

    // Fill RX1 past depth, then drain and underrun.
    bus.rx2_en = 0;
    for (int k = 1; k <= 9; k++) begin push(0, 24'(k), 24'(~k)); step(); end
    check("t3_ovr", 64'(bus.overrun), 64'd1);
    for (int k = 1; k <= 9; k++) begin
      bus.read_req = 1; step();
      check("t3_empty", 64'(bus.out_empty), 64'(k == 9));
      check("t3_i", 64'($unsigned(bus.out_i)), (k == 9) ? 64'd0 : 64'(k));
    end

    // Full FIFO with simultaneous push and pop.
    bus.overrun_clr = 1; step();
    for (int k = 1; k <= 8; k++) begin push(0, 24'(16 + k), 24'h5); step(); end
    push(0, 24'h99, 24'h98); bus.read_req = 1; step();
    check("t4_ovr", 64'(bus.overrun), 64'd0);
    for (int k = 0; k < 8; k++) begin bus.read_req = 1; step(); end
    check("t4_last", 64'($unsigned(bus.out_i)), 64'h99);

    // RX2 disabled while its slot is pending.
    bus.rx2_en = 1;
    push(0, 24'h111, 24'h1); step();
    push(1, 24'h222, 24'h2); step();
    push(0, 24'h333, 24'h3); step();
    bus.read_req = 1; step();
    bus.rx2_en = 0; bus.read_req = 1; step();
    check("t5_ch", 64'(bus.out_ch), 64'd0);
    check("t5_i", 64'($unsigned(bus.out_i)), 64'h333);
    bus.rx2_en = 1; bus.read_req = 1; step();
    bus.read_req = 1; step();
    check("t5_flush", 64'({bus.out_ch, bus.out_empty}), 64'b11);

    // Drop counting and clear/drop collision.
    bus.rx2_en = 0;
    bus.overrun_clr = 1; step();
    for (int k = 0; k < 11; k++) begin push(0, 24'(k), 24'(k)); step(); end
`ifdef IQ_SCHED_OVERRUN_CNT_EN
    check("t6_cnt3", 64'(bus.overrun_cnt), 64'd3);
`endif
    push(0, 24'hEE, 24'hEE); bus.overrun_clr = 1; step();
    check("t6_ovr", 64'(bus.overrun), 64'd1);
`ifdef IQ_SCHED_OVERRUN_CNT_EN
    check("t6_cnt1", 64'(bus.overrun_cnt), 64'd1);
`endif
    for (int k = 0; k < 8; k++) begin bus.read_req = 1; step(); end

    // Randomized traffic.
    bus.rx1_en = 1; bus.rx2_en = 1;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(63) == 0) bus.rx1_en = ~bus.rx1_en;
      if ($urandom_range(63) == 0) bus.rx2_en = ~bus.rx2_en;
      if ($urandom_range(1) == 0) push(0, 24'($urandom), 24'($urandom));
      if ($urandom_range(1) == 0) push(1, 24'($urandom), 24'($urandom));
      bus.read_req    = ($urandom_range(9) < 4);
      bus.overrun_clr = ($urandom_range(31) == 0);
      rst             = ($urandom_range(255) == 0);
      step();
      rst = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
